lab2_sys_pio_in_capture: RTL and testbench

- Avalon-MM slave input PIO: the read-side counterpart of the system's output PIOs. It samples WIDTH external pins (switches/keys) into the clock domain and can debounce them.
- Exposes the level, a per-bit edge-capture register and an interrupt mask to the Nios II CPU.
- Drives a level-sensitive IRQ to the interrupt controller.

---
 rtl/lab2_sys_pio_in_capture.sv | 125 ++++++++++++
 tb/tb_lab2_sys_pio_in_capture.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_sys_pio_in_capture.sv
// Avalon-MM input PIO: synchronizes WIDTH pins, optionally debounces them,
// and exposes level / irqmask / edgecap registers plus a level IRQ.
// Optional per-bit debounce filter is enabled by defining PIO_IN_DEBOUNCE_EN.

// Per-pin front end: synchronizer chain followed by the level filter.
module lab2_sys_pio_in_capture_bit #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic lvl
);
   logic [SYNC_STAGES-1:0] sync;
   logic                   s;

   if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("lab2_sys_pio_in_capture: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
   end

   // Synchronizer shift chain; the last stage is the first usable sample.
   always_ff @(posedge clk) begin
      if (reset) sync <= '0;
      else       sync <= {sync[SYNC_STAGES-2:0], pin};
   end

   assign s = sync[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [CW-1:0] cnt;

   // Level only follows s after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         lvl <= 1'b0;
      end else if (s == lvl) begin
         cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
         lvl <= s;
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
`else
   // Without the filter the level is simply one more register after s.
   always_ff @(posedge clk) begin
      if (reset) lvl <= 1'b0;
      else       lvl <= s;
   end
`endif
endmodule

module lab2_sys_pio_in_capture #(
   parameter int WIDTH           = 12,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int EDGE_TYPE       = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);
   logic [WIDTH-1:0] lvl, lvl_prev, irqmask, edgecap, ev;
   logic             wr_en;
   logic             unused_wdata;

   assign unused_wdata = &{1'b0, writedata};
   assign wr_en        = chipselect & ~write_n;

   lab2_sys_pio_in_capture_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_bit [WIDTH-1:0] (
      .clk   (clk),
      .reset (reset),
      .pin   (in_port),
      .lvl   (lvl)
   );

   // Edge event selection; EDGE_TYPE is static so this folds to wires.
   always_comb begin
      case (EDGE_TYPE)
         0:       ev = lvl & ~lvl_prev;
         1:       ev = ~lvl & lvl_prev;
         default: ev = lvl ^ lvl_prev;
      endcase
   end

   // Edge history, mask register and sticky edge capture (set beats clear).
   always_ff @(posedge clk) begin
      if (reset) begin
         lvl_prev <= '0;
         irqmask  <= '0;
         edgecap  <= '0;
      end else begin
         lvl_prev <= lvl;
         if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
         if (wr_en && address == 2'd3) edgecap <= (edgecap & ~writedata[WIDTH-1:0]) | ev;
         else                          edgecap <= edgecap | ev;
      end
   end

   // Zero-latency read mux; unused upper bits read as 0.
   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata[WIDTH-1:0] = lvl;
         2'd2:    readdata[WIDTH-1:0] = irqmask;
         2'd3:    readdata[WIDTH-1:0] = edgecap;
         default: readdata = '0;
      endcase
   end

   assign irq = |(edgecap & irqmask);
endmodule

// File: tb/tb_lab2_sys_pio_in_capture.sv
module tb_lab2_sys_pio_in_capture;
   localparam int W   = 12;
   localparam int SS  = 2;
   localparam int DBN = 4;
`ifdef PIO_IN_DEBOUNCE_EN
   localparam int EFF_D = DBN;
   localparam int LAT   = SS - 1 + DBN;  // edges from pin sample to lvl change
`else
   localparam int EFF_D = 1;
   localparam int LAT   = SS;
`endif
   localparam int HLEN = SS + EFF_D;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [W-1:0]  in_port;
   logic [31:0]   readdata;
   logic          irq;

   int n_checks = 0;
   int n_err    = 0;

   lab2_sys_pio_in_capture #(
      .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DBN), .EDGE_TYPE(0)
   ) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: pin history window; a bit's level flips once the last EFF_D
   // synchronized samples all disagree with it.
   logic [W-1:0] hist [0:HLEN-1];
   logic [W-1:0] m_lvl, m_prev, m_mask, m_cap;
   bit           m_valid = 1'b0;

   function automatic logic [W-1:0] model_next_lvl();
      logic [W-1:0] r;
      bit moved;
      r = m_lvl;
      for (int b = 0; b < W; b++) begin
         moved = 1'b1;
         for (int i = 0; i < EFF_D; i++)
            if (hist[SS-1+i][b] == m_lvl[b]) moved = 1'b0;
         if (moved) r[b] = ~m_lvl[b];
      end
      return r;
   endfunction

   function automatic logic [31:0] model_rd(input logic [1:0] a);
      case (a)
         2'd0:    return {20'd0, m_lvl};
         2'd2:    return {20'd0, m_mask};
         2'd3:    return {20'd0, m_cap};
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_lvl  <= '0;
         m_prev <= '0;
         m_mask <= '0;
         m_cap  <= '0;
         for (int i = 0; i < HLEN; i++) hist[i] <= '0;
         m_valid <= 1'b1;
      end else begin
         if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[W-1:0];
         if (chipselect && !write_n && address == 2'd3)
            m_cap <= (m_cap & ~writedata[W-1:0]) | (m_lvl & ~m_prev);
         else
            m_cap <= m_cap | (m_lvl & ~m_prev);
         m_prev <= m_lvl;
         m_lvl  <= model_next_lvl();
         hist[0] <= in_port;
         for (int i = 1; i < HLEN; i++) hist[i] <= hist[i-1];
      end
   end

   // Every-cycle compare of the read mux and irq against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         check("model_readdata", readdata, model_rd(address));
         check("model_irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
      address = a;
      #1;
      check(name, readdata, exp);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   initial begin
      reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = 32'd0; in_port = '0;
      tick(2);
      reset = 1'b0;

      // Reset state
      rd(0, 32'h0, "rst_lvl");
      rd(1, 32'h0, "rst_a1");
      rd(2, 32'h0, "rst_mask");
      rd(3, 32'h0, "rst_cap");
      check("rst_irq", {31'd0, irq}, 32'd0);

      // Level read and latency
      in_port = 12'h0A5;
      for (int i = 0; i < LAT; i++) begin
         tick(1);
         rd(0, 32'h0, "lat_lvl_early");
      end
      tick(1);
      rd(0, 32'h0000_00A5, "lat_lvl");
      rd(3, 32'h0, "lat_cap_early");
      tick(1);
      rd(3, 32'h0000_00A5, "lat_cap");
      check("lat_irq_mask0", {31'd0, irq}, 32'd0);
      wr(3, 32'hFFF);
      rd(3, 32'h0, "cap_cleared");
      in_port = '0;
      tick(LAT + 2);
      rd(0, 32'h0, "fall_lvl");
      rd(3, 32'h0, "fall_no_cap");

`ifdef PIO_IN_DEBOUNCE_EN
      // Debounce reject: 3-cycle runs never reach the 4-sample threshold
      for (int r = 0; r < 10; r++) begin
         in_port[0] = 1'b1; tick(3);
         in_port[0] = 1'b0; tick(3);
      end
      tick(2);
      rd(0, 32'h0, "bounce_lvl");
      rd(3, 32'h0, "bounce_cap");
      check("bounce_irq", {31'd0, irq}, 32'd0);
      in_port[0] = 1'b1;
      tick(LAT + 2);
      rd(0, 32'h1, "stable_lvl");
      rd(3, 32'h1, "stable_cap");
`else
      // Single-cycle pulse on bit5 is captured without a filter
      in_port[5] = 1'b1;
      tick(1);
      in_port[5] = 1'b0;
      tick(1);
      rd(0, 32'h0, "pulse_lvl_early");
      tick(1);
      rd(0, 32'h20, "pulse_lvl");
      rd(3, 32'h0, "pulse_cap_early");
      tick(1);
      rd(0, 32'h0, "pulse_lvl_gone");
      rd(3, 32'h20, "pulse_cap");
`endif
      in_port = '0;
      tick(LAT + 2);
      wr(3, 32'hFFF);
      rd(3, 32'h0, "cap_clear2");

      // IRQ mask and clear
      wr(2, 32'h1);
      rd(2, 32'h1, "mask_rd");
      in_port = 12'h001;
      tick(LAT + 2);
      check("irq_set", {31'd0, irq}, 32'd1);
      wr(3, 32'h1);
      rd(3, 32'h0, "irq_w1c_cap");
      check("irq_w1c", {31'd0, irq}, 32'd0);
      in_port = '0;
      tick(LAT + 2);
      in_port = 12'h001;
      tick(LAT + 2);
      check("irq_set2", {31'd0, irq}, 32'd1);
      wr(2, 32'h0);
      check("irq_masked", {31'd0, irq}, 32'd0);
      rd(3, 32'h1, "masked_cap_kept");

      // Set-wins: the clear write lands on the edge where ev[3] is high
      in_port = 12'h009;
      tick(LAT + 1);
      wr(3, 32'hFFF);
      rd(3, 32'h008, "set_wins");

      // Reset mid-operation
      wr(2, 32'hFFF);
      in_port = '0;
      tick(LAT + 2);
      in_port = 12'hFFF;
      tick(LAT + 2);
      rd(3, 32'hFFF, "pre_rst_cap");
      check("pre_rst_irq", {31'd0, irq}, 32'd1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("post_rst_irq", {31'd0, irq}, 32'd0);
      rd(0, 32'h0, "post_rst_lvl");
      rd(1, 32'h0, "post_rst_a1");
      rd(2, 32'h0, "post_rst_mask");
      rd(3, 32'h0, "post_rst_cap");
      tick(LAT + 1);
      rd(0, 32'hFFF, "held_lvl");
      rd(3, 32'h0, "held_cap_early");
      tick(1);
      rd(3, 32'hFFF, "held_cap");

      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
